// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory port: mem_size encoding, read FSM states,
// default address limit and the store lane-mask helper.
package mem_port_pkg;

   // Bit positions inside the one-hot mem_size field (all zero means word)
   localparam int unsigned SizeByteS = 3;
   localparam int unsigned SizeByteU = 2;
   localparam int unsigned SizeHalfS = 1;
   localparam int unsigned SizeHalfU = 0;

   // Highest legal byte address
   localparam logic [31:0] AddrLimitDefault = 32'h0008_0000;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StResp,
      StRelease
   } rd_state_e;

   // Lane mask for a store of the given size, before shifting to its byte offset
   function automatic logic [3:0] store_mask(input logic [3:0] size);
      logic [3:0] mask;
      if (size[SizeByteS] || size[SizeByteU]) begin
         mask = 4'b0001;
      end else if (size[SizeHalfS] || size[SizeHalfU]) begin
         mask = 4'b0011;
      end else begin
         mask = 4'b1111;
      end
      return mask;
   endfunction

endpackage

// File: rtl/mem_port_load_align.sv
// Load alignment: picks the addressed byte/half out of the SRAM word and
// sign- or zero-extends it; word loads pass straight through.
module load_align
   import mem_port_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [3:0]  size,
   output logic [31:0] dout
);

   logic [31:0] shifted;

   // Shift the addressed lane down to bit 0, then extend according to size
   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      if (size[SizeByteS]) begin
         dout = {{24{shifted[7]}}, shifted[7:0]};
      end else if (size[SizeByteU]) begin
         dout = {24'h0, shifted[7:0]};
      end else if (size[SizeHalfS]) begin
         dout = {{16{shifted[15]}}, shifted[15:0]};
      end else if (size[SizeHalfU]) begin
         dout = {16'h0, shifted[15:0]};
      end else begin
         dout = rdata;
      end
   end

endmodule

// File: rtl/mem_port.sv
// Memory port between the control unit / shared bus and a synchronous SRAM.
// Reads run through a small FSM with a configurable number of wait states;
// writes are posted into a one-entry buffer and drained when no read is
// using the SRAM, so read and write strobes never overlap.
module mem_port
   import mem_port_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] ADDR_LIMIT  = AddrLimitDefault
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] bus_in,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_size,
   input  logic        mem_addr_ready,
   output logic        mem_data_ready,
   output logic        mem_bus,
   output logic [31:0] mem_dout,
   output logic [16:0] sram_addr,
   output logic [31:0] sram_wdata,
   output logic [3:0]  sram_be,
   output logic        sram_re,
   output logic        sram_we,
   input  logic [31:0] sram_rdata
);

   localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   rd_state_e   state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic [18:0] rd_addr_q;
   logic [3:0]  rd_size_q;

   logic        wr_valid_q, wr_valid_d;
   logic [18:0] wr_addr_q;
   logic [31:0] wr_data_q;
   logic [3:0]  wr_size_q;

   logic        addr_ok;
   logic        wr_load;
   logic        drain;
   logic        rd_accept;
   logic [31:0] ext_data;
   logic [31:0] wr_lanes;

   load_align u_load_align (
      .rdata  (sram_rdata),
      .offset (rd_addr_q[1:0]),
      .size   (rd_size_q),
      .dout   (ext_data)
   );

   // Request qualification and write-buffer control
   always_comb begin
      addr_ok = (addr <= ADDR_LIMIT);
      wr_load = mem_write & addr_ok;
      // The buffer only drains while the SRAM is not busy with a read
      drain   = wr_valid_q & ((state_q == StIdle) | (state_q == StRelease));
      // In IDLE any buffered write drains this very cycle, so only a write
      // arriving on the same edge has to hold the read off.
      rd_accept = (state_q == StIdle) & mem_read & mem_addr_ready & ~mem_write & addr_ok;
      wr_valid_d = wr_load | (wr_valid_q & ~drain);
   end

   // Read FSM next state and wait-state counter
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         StIdle: begin
            if (rd_accept) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (!mem_read) begin
               state_d = StIdle;
            end else if (WAIT_STATES > 0) begin
               state_d = StWait;
               wait_d  = WaitLoad;
            end else begin
               state_d = StResp;
            end
         end
         StWait: begin
            if (!mem_read) begin
               state_d = StIdle;
               wait_d  = 4'd0;
            end else if (wait_q == 4'd0) begin
               state_d = StResp;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         StResp: begin
            // A dropped mem_read here is a trap: skip RELEASE
            state_d = mem_read ? StRelease : StIdle;
         end
         StRelease: begin
            if (!mem_addr_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, latched read request and posted-write buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         wait_q     <= 4'd0;
         rd_addr_q  <= '0;
         rd_size_q  <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_size_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         wr_valid_q <= wr_valid_d;
         if (rd_accept) begin
            rd_addr_q <= addr[18:0];
            rd_size_q <= mem_size;
         end
         if (wr_load) begin
            wr_addr_q <= addr[18:0];
            wr_data_q <= bus_in;
            wr_size_q <= mem_size;
         end
      end
   end

   // Replicate store data across every lane it could land in
   always_comb begin
      if (wr_size_q[SizeByteS] || wr_size_q[SizeByteU]) begin
         wr_lanes = {4{wr_data_q[7:0]}};
      end else if (wr_size_q[SizeHalfS] || wr_size_q[SizeHalfU]) begin
         wr_lanes = {2{wr_data_q[15:0]}};
      end else begin
         wr_lanes = wr_data_q;
      end
   end

   // Output drive; everything is forced low while reset is asserted
   always_comb begin
      mem_data_ready = 1'b0;
      mem_bus        = 1'b0;
      mem_dout       = 32'h0;
      sram_addr      = 17'h0;
      sram_wdata     = 32'h0;
      sram_be        = 4'h0;
      sram_re        = 1'b0;
      sram_we        = 1'b0;
      if (!reset) begin
         if ((state_q == StResp) && mem_read) begin
            mem_data_ready = 1'b1;
            mem_bus        = 1'b1;
            mem_dout       = ext_data;
         end
         if (state_q == StIssue) begin
            sram_re   = 1'b1;
            sram_addr = rd_addr_q[18:2];
         end
         if (drain) begin
            sram_we    = 1'b1;
            sram_addr  = wr_addr_q[18:2];
            sram_be    = store_mask(wr_size_q) << wr_addr_q[1:0];
            sram_wdata = wr_lanes;
         end
      end
   end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: one instance with one wait state and one with
// three, sharing stimulus, each backed by its own behavioural SRAM.
module tb_mem_port;
   import mem_port_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, bus_in;
   logic        mem_read, mem_write, mem_addr_ready;
   logic [3:0]  mem_size;

   logic        a_ready, a_bus, a_re, a_we;
   logic [31:0] a_dout, a_wdata, a_rdata;
   logic [16:0] a_saddr;
   logic [3:0]  a_be;

   logic        b_ready, b_bus, b_re, b_we;
   logic [31:0] b_dout, b_wdata, b_rdata;
   logic [16:0] b_saddr;
   logic [3:0]  b_be;

   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];

   int   passed = 0;
   int   total  = 0;
   logic overlap = 1'b0;

   localparam logic [3:0] LB = 4'b1000, LBU = 4'b0100, LH = 4'b0010, LHU = 4'b0001, LW = 4'b0000;

   always #5 clk = ~clk;

   mem_port #(.WAIT_STATES(1)) dut_a (
      .clk(clk), .reset(reset), .addr(addr), .bus_in(bus_in), .mem_read(mem_read),
      .mem_write(mem_write), .mem_size(mem_size), .mem_addr_ready(mem_addr_ready),
      .mem_data_ready(a_ready), .mem_bus(a_bus), .mem_dout(a_dout), .sram_addr(a_saddr),
      .sram_wdata(a_wdata), .sram_be(a_be), .sram_re(a_re), .sram_we(a_we),
      .sram_rdata(a_rdata)
   );

   mem_port #(.WAIT_STATES(3)) dut_b (
      .clk(clk), .reset(reset), .addr(addr), .bus_in(bus_in), .mem_read(mem_read),
      .mem_write(mem_write), .mem_size(mem_size), .mem_addr_ready(mem_addr_ready),
      .mem_data_ready(b_ready), .mem_bus(b_bus), .mem_dout(b_dout), .sram_addr(b_saddr),
      .sram_wdata(b_wdata), .sram_be(b_be), .sram_re(b_re), .sram_we(b_we),
      .sram_rdata(b_rdata)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] w;
      w = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) w[8*i +: 8] = d[8*i +: 8];
      end
      return w;
   endfunction

   // Behavioural SRAMs: read data appears the cycle after the strobe and holds
   always @(posedge clk) begin
      if (a_we) mem_a[a_saddr[9:0]] <= merge(mem_a[a_saddr[9:0]], a_wdata, a_be);
      if (a_re) a_rdata <= mem_a[a_saddr[9:0]];
      if (b_we) mem_b[b_saddr[9:0]] <= merge(mem_b[b_saddr[9:0]], b_wdata, b_be);
      if (b_re) b_rdata <= mem_b[b_saddr[9:0]];
   end

   always @(negedge clk) begin
      if ((a_re && a_we) || (b_re && b_we)) overlap <= 1'b1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   // Posted store; checks the drain cycle on instance A
   task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] size, input logic [3:0] be, input logic [31:0] wd);
      addr = a; bus_in = d; mem_size = size; mem_write = 1'b1;
      tick;
      mem_write = 1'b0;
      chk({tag, "_we_be"}, {a_we, a_be}, {1'b1, be});
      chk({tag, "_wdata"}, a_wdata, wd);
      chk({tag, "_saddr"}, a_saddr, a[18:2]);
      tick;
   endtask

   // Full read transaction with exact latency check on the selected instance
   task automatic load(input string tag, input bit sel_b, input int ws, input logic [31:0] a,
                       input logic [3:0] size, input logic [31:0] exp);
      addr = a; mem_size = size; mem_read = 1'b1; mem_addr_ready = 1'b1;
      tick;
      chk({tag, "_re"}, sel_b ? b_re : a_re, 1'b1);
      for (int i = 1; i <= ws; i++) begin
         tick;
         chk({tag, "_early"}, sel_b ? b_ready : a_ready, 1'b0);
      end
      tick;
      chk({tag, "_rdy_bus"}, sel_b ? {b_ready, b_bus} : {a_ready, a_bus}, 2'b11);
      chk({tag, "_dout"}, sel_b ? b_dout : a_dout, exp);
      tick;
      chk({tag, "_release"}, sel_b ? {b_ready, b_bus, b_dout} : {a_ready, a_bus, a_dout}, '0);
      mem_read = 1'b0; mem_addr_ready = 1'b0;
      tick;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 32'h0;
         mem_b[i] = 32'h0;
      end
      a_rdata = 32'h0; b_rdata = 32'h0;
      reset = 1'b1; addr = 32'h0; bus_in = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
      mem_size = LW; mem_addr_ready = 1'b0;
      tick; tick;
      chk("rst_a", {a_ready, a_bus, a_dout, a_saddr, a_wdata, a_be, a_re, a_we}, '0);
      chk("rst_b", {b_ready, b_bus, b_dout, b_saddr, b_wdata, b_be, b_re, b_we}, '0);
      reset = 1'b0;
      tick;
      chk("idle_a", {a_ready, a_bus, a_dout, a_saddr, a_wdata, a_be, a_re, a_we}, '0);

      // Word store then word load, two-cycle latency
      store("sw100", 32'h100, 32'hDEADBEEF, LW, 4'b1111, 32'hDEADBEEF);
      load("lw100", 1'b0, 1, 32'h100, LW, 32'hDEADBEEF);

      // Sub-word extraction and extension
      store("sw200", 32'h200, 32'h80FF7F01, LW, 4'b1111, 32'h80FF7F01);
      load("lb201", 1'b0, 1, 32'h201, LB, 32'h0000007F);
      load("lb202", 1'b0, 1, 32'h202, LB, 32'hFFFFFFFF);
      load("lbu203", 1'b0, 1, 32'h203, LBU, 32'h00000080);
      load("lh202", 1'b0, 1, 32'h202, LH, 32'hFFFF80FF);
      load("lhu200", 1'b0, 1, 32'h200, LHU, 32'h00007F01);

      // Byte and half stores merge into a zeroed word
      store("sb305", 32'h305, 32'h000000AB, LB, 4'b0010, 32'hABABABAB);
      store("sh306", 32'h306, 32'h00001234, LH, 4'b1100, 32'h12341234);
      load("lw304", 1'b0, 1, 32'h304, LW, 32'h1234AB00);

      // Store immediately followed by a fetch: drain first, read next cycle
      addr = 32'h400; bus_in = 32'h55AA55AA; mem_size = LW; mem_write = 1'b1;
      tick;
      mem_write = 1'b0; mem_read = 1'b1; mem_addr_ready = 1'b1;
      chk("raw_drain", {a_we, a_re}, 2'b10);
      tick;
      chk("raw_issue", {a_we, a_re}, 2'b01);
      tick;
      chk("raw_wait", a_ready, 1'b0);
      tick;
      chk("raw_rdy", a_ready, 1'b1);
      chk("raw_dout", a_dout, 32'h55AA55AA);
      tick;
      mem_read = 1'b0; mem_addr_ready = 1'b0;
      tick;

      // Write arriving mid-read is held until the read has finished
      addr = 32'h100; mem_size = LW; mem_read = 1'b1; mem_addr_ready = 1'b1;
      tick;
      chk("wir_re", a_re, 1'b1);
      addr = 32'h108; bus_in = 32'h11112222; mem_write = 1'b1;
      tick;
      mem_write = 1'b0;
      chk("wir_we_wait", a_we, 1'b0);
      tick;
      chk("wir_rdy", {a_ready, a_we}, 2'b10);
      chk("wir_dout", a_dout, 32'hDEADBEEF);
      tick;
      chk("wir_drain", {a_we, a_saddr}, {1'b1, 17'h42});
      mem_read = 1'b0; mem_addr_ready = 1'b0;
      tick;
      load("lw108", 1'b0, 1, 32'h108, LW, 32'h11112222);

      // Out-of-range requests are ignored; the limit itself is legal
      addr = 32'h80004; mem_size = LW; mem_read = 1'b1; mem_addr_ready = 1'b1;
      tick;
      chk("oor_rd0", {a_re, b_re}, 2'b00);
      tick;
      chk("oor_rd1", {a_re, a_ready}, 2'b00);
      mem_read = 1'b0; mem_addr_ready = 1'b0;
      tick;
      addr = 32'h90000; bus_in = 32'hFFFFFFFF; mem_write = 1'b1;
      tick;
      mem_write = 1'b0;
      chk("oor_wr", {a_we, b_we}, 2'b00);
      tick;
      load("lw_limit", 1'b0, 1, 32'h80000, LW, 32'h0);

      // Trap: mem_read dropped during WAIT on the three-wait-state port
      addr = 32'h100; mem_size = LW; mem_read = 1'b1; mem_addr_ready = 1'b1;
      tick;
      chk("trap_re", b_re, 1'b1);
      tick;
      chk("trap_w1", b_ready, 1'b0);
      tick;
      chk("trap_w2", b_ready, 1'b0);
      mem_read = 1'b0; mem_addr_ready = 1'b0;
      tick;
      chk("trap_idle", dut_b.state_q, StIdle);
      chk("trap_nordy", b_ready, 1'b0);
      tick;
      chk("trap_nordy2", b_ready, 1'b0);
      load("lw_b", 1'b1, 3, 32'h100, LW, 32'hDEADBEEF);

      // Reset during WAIT clears everything
      addr = 32'h200; mem_size = LW; mem_read = 1'b1; mem_addr_ready = 1'b1;
      tick;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0; mem_read = 1'b0; mem_addr_ready = 1'b0;
      chk("rstw_b", {b_ready, b_bus, b_dout, b_saddr, b_wdata, b_be, b_re, b_we}, '0);
      chk("rstw_a", {a_ready, a_bus, a_dout, a_saddr, a_wdata, a_be, a_re, a_we}, '0);
      tick;
      chk("rstw_b_after", {b_ready, b_re, b_we}, 3'b000);

      // Reset with a pending write discards it
      addr = 32'h500; bus_in = 32'hCAFEF00D; mem_size = LW; mem_write = 1'b1;
      tick;
      mem_write = 1'b0; reset = 1'b1;
      #1;
      chk("rstwr_gate", {a_we, b_we}, 2'b00);
      tick;
      reset = 1'b0;
      #1;
      chk("rstwr_clr", {a_we, b_we}, 2'b00);
      tick;
      load("lw500", 1'b0, 1, 32'h500, LW, 32'h0);

      chk("no_overlap", overlap, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 Parameter WAIT_STATES, default 1: extra SRAM read cycles, legal 0..15.
REQ-002 Parameter ADDR_LIMIT, default 32'h80000: highest legal byte address.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 addr  in  32  byte address from the control unit.
REQ-006 bus_in  in  32  store data from the shared bus.
REQ-007 mem_read  in  1  read request (instruction fetch or load).
REQ-008 mem_write  in  1  store request.
REQ-009 mem_size  in  4  one-hot: [3]=byte signed, [2]=byte unsigned, [1]=half signed, [0]=half unsigned, 0=word; stores use only [3], [1] or 0.
REQ-010 mem_addr_ready  in  1  address-valid strobe from the control unit.
REQ-011 mem_data_ready  out  1  one-cycle read-complete pulse.
REQ-012 mem_bus  out  1  mem_port drives the shared bus this cycle.
REQ-013 mem_dout  out  32  extended load data; 0 when mem_bus=0.
REQ-014 sram_addr  out  17  word address (addr[18:2]).
REQ-015 sram_wdata  out  32  lane-aligned write data.
REQ-016 sram_be  out  4  byte enables for writes.
REQ-017 sram_re  out  1  read strobe.
REQ-018 sram_we  out  1  write strobe.
REQ-019 sram_rdata  in  32  read word, valid from the cycle after sram_re until the next strobe.

Function
REQ-020 Read FSM states: IDLE, ISSUE, WAIT, RESP, RELEASE.
REQ-021 IDLE->ISSUE on posedge with mem_read & mem_addr_ready & no write pending & addr<=ADDR_LIMIT; addr and mem_size are latched on that edge.
REQ-022 ISSUE: sram_re=1 for one cycle; next state is WAIT if WAIT_STATES>0, else RESP.
REQ-023 WAIT: down-counter loaded with WAIT_STATES-1; exit to RESP when it reaches 0.
REQ-024 RESP lasts exactly one cycle with mem_data_ready=1, mem_bus=1, mem_dout=extend(sram_rdata); next state is RELEASE.
REQ-025 Read latency: mem_data_ready is high during cycle 1+WAIT_STATES after the sampling edge.
REQ-026 RELEASE->IDLE when mem_addr_ready=0; no new read is accepted before that.
REQ-027 Extraction: byte=rdata[8*a+7:8*a] and half=rdata[8*a+15:8*a], where a=latched addr[1:0]; signed sizes sign-extend, unsigned sizes zero-extend, word passes through.
REQ-028 Writes are posted: every posedge with mem_write=1 loads a one-entry buffer (addr, bus_in, mem_size); mem_data_ready is never pulsed for writes.
REQ-029 The buffered write drains in the following cycle: sram_we=1, sram_be is the lane mask shifted by addr[1:0] (byte 0001, half 0011, word 1111), data replicated across lanes.
REQ-030 While a write is pending, reads stall in IDLE, so read-after-write to the same word returns the new data.
REQ-031 A write arriving while a read is in flight is buffered and drains after RESP; sram_re and sram_we are never asserted together.
REQ-032 A write to addr>ADDR_LIMIT is discarded (no sram_we); a read request to addr>ADDR_LIMIT is not accepted.
REQ-033 If mem_read falls in ISSUE, WAIT or RESP (trap), the FSM returns to IDLE next edge and no mem_data_ready pulse occurs.
REQ-034 Half at addr[1:0]=11 (never issued by control) is undefined and need not be checked.

Reset
REQ-035 On reset the FSM is in IDLE, the wait counter and write buffer are cleared, and all outputs are 0, including during an in-flight read or pending write.

Structure
REQ-036 A shared package holds the mem_size bit positions, the FSM state enum and ADDR_LIMIT.
REQ-037 The combinational extract/extend logic is a sub-module, load_align.

Verification
REQ-038 WAIT_STATES=1, word store 0xDEADBEEF @0x100, then LW @0x100 -> sram_we,be=1111; mem_dout=0xDEADBEEF with mem_data_ready high exactly 2 cycles after the sampling edge.
REQ-039 Word 0x80FF7F01 @0x200: LB @0x201=0x0000007F, LB @0x202=0xFFFFFFFF, LBU @0x203=0x00000080, LH @0x202=0xFFFF80FF, LHU @0x200=0x00007F01.
REQ-040 SB 0xAB @0x305 then SH 0x1234 @0x306 -> be=0010 then 1100; a later LW @0x304 returns 0x1234AB00 over a zeroed word.
REQ-041 Store immediately followed by a fetch request -> the write drains first, the read issues one cycle later, and the strobes never overlap.
REQ-042 mem_read dropped during WAIT (WAIT_STATES=3) -> no mem_data_ready pulse, FSM in IDLE, and the next read completes normally.
REQ-043 Read to 0x80004 and store to 0x90000 -> no sram_re/sram_we; reset asserted during WAIT -> all outputs 0 on the next cycle.
